// File: rtl/toggle_pulse_decoder.sv
// toggle_pulse_decoder: recovers one pulse per toggle of an async toggle-encoded line
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   tog_in         toggle-encoded event line (async to clk)
//   en             decode enable
//   clr_cnt        synchronous clear of evt_cnt and overrun
//   pulse_out      one-cycle pulse per accepted event
//   level_out      last accepted/tracked synchronised level
//   evt_cnt        accepted-event count, wraps silently
//   overrun        sticky: toggle seen while holding off after an event
//   state_o        FSM state (DISABLED=0, ARMED=1, HOLD=2)
module toggle_pulse_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             pulse_out,
  output logic             level_out,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             overrun,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {DISABLED = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;
  localparam int GW = $clog2(MIN_GAP + 1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic sync_prev_q, ref_q, ref_d, pulse_q, pulse_d, ovr_q, ovr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sync_out, edge_det, acc, ovr_det;
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out ^ ref_q;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], tog_in};
  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    gap_d = gap_q;
    acc = 1'b0;
    ovr_det = 1'b0;
    case (state_q)
      ARMED: begin
        acc = en & edge_det;
        ref_d = acc ? sync_out : ref_q;
        gap_d = acc ? GW'(MIN_GAP) : gap_q;
        state_d = !en ? DISABLED : (acc ? HOLD : ARMED);
      end
      HOLD: begin
        // Any movement of the synchronised line while holding off is an overrun;
        // the reference stays frozen so ARMED later sees only the net change.
        ovr_det = sync_out ^ sync_prev_q;
        gap_d = en ? gap_q - GW'(1) : '0;
        state_d = !en ? DISABLED : (gap_q == GW'(1) ? ARMED : HOLD);
      end
      default: begin
        // Track the line while disabled so enabling never fabricates an event.
        ref_d = sync_out;
        gap_d = '0;
        state_d = en ? ARMED : DISABLED;
      end
    endcase
    pulse_d = acc;
    cnt_d = (clr_cnt ? '0 : cnt_q) + CNT_W'(acc);
    ovr_d = (clr_cnt ? 1'b0 : ovr_q) | ovr_det;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISABLED;
      sync_q <= '0;
      sync_prev_q <= 1'b0;
      ref_q <= 1'b0;
      gap_q <= '0;
      pulse_q <= 1'b0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      sync_prev_q <= sync_out;
      ref_q <= ref_d;
      gap_q <= gap_d;
      pulse_q <= pulse_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end
  assign pulse_out = pulse_q;
  assign level_out = ref_q;
  assign evt_cnt = cnt_q;
  assign overrun = ovr_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// tb_toggle_pulse_decoder: scoreboard bench for toggle_pulse_decoder (SYNC_STAGES=2, MIN_GAP=2, CNT_W=8)
module tb_toggle_pulse_decoder;
  logic clk = 1'b0, rst = 1'b1, tog_in = 1'b1, en = 1'b0, clr_cnt = 1'b0;
  logic pulse_out, level_out, overrun;
  logic [7:0] evt_cnt;
  logic [1:0] state_o;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;
  typedef struct {int c; int cnt; logic lvl; logic ovr;} exp_t;
  exp_t q[$];
  toggle_pulse_decoder #(.SYNC_STAGES(2), .MIN_GAP(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tog_in(tog_in), .en(en), .clr_cnt(clr_cnt),
    .pulse_out(pulse_out), .level_out(level_out), .evt_cnt(evt_cnt),
    .overrun(overrun), .state_o(state_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Flip the line and book the pulse it must produce lat edges from now.
  task automatic tog(input int lat, input logic ovr);
    tog_in = ~tog_in;
    exp_cnt++;
    q.push_back('{cyc + lat, int'(exp_cnt), tog_in, ovr});
  endtask
  always @(negedge clk) begin
    if (!rst && pulse_out) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_cnt", int'(evt_cnt), e.cnt);
        chk("pulse_level", int'(level_out), int'(e.lvl));
        chk("pulse_overrun", int'(overrun), int'(e.ovr));
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_level", int'(level_out), 0);
    chk("rst_cnt", int'(evt_cnt), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_state", int'(state_o), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_level", int'(level_out), 1);
    chk("dis_cnt", int'(evt_cnt), 0);
    chk("dis_state", int'(state_o), 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("armed_state", int'(state_o), 1);
    tog(3, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold1_state", int'(state_o), 2);
    @(negedge clk);
    chk("hold2_state", int'(state_o), 2);
    @(negedge clk);
    chk("rearm_state", int'(state_o), 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      tog(3, 1'b0);
      repeat (6) @(negedge clk);
    end
    chk("train_cnt", int'(evt_cnt), 11);
    chk("train_ovr", int'(overrun), 0);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    exp_cnt = 8'd0;
    chk("clr_cnt", int'(evt_cnt), 0);
    for (int i = 0; i < 256; i++) begin
      tog(3, 1'b0);
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("wrap_cnt", int'(evt_cnt), 0);
    chk("gap3_ovr", int'(overrun), 0);
    tog(3, 1'b0);
    @(negedge clk);
    tog(5, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovr_hold_state", int'(state_o), 2);
    chk("ovr_hold_flag", int'(overrun), 1);
    repeat (6) @(negedge clk);
    chk("ovr_cnt", int'(evt_cnt), 2);
    exp_cnt = 8'd0;
    tog(3, 1'b0);
    repeat (2) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    repeat (6) @(negedge clk);
    tog(3, 1'b0);
    repeat (3) @(negedge clk);
    chk("dis_hold_state", int'(state_o), 2);
    en = 1'b0;
    @(negedge clk);
    chk("dis_mid_state", int'(state_o), 0);
    tog_in = ~tog_in;
    repeat (4) @(negedge clk);
    chk("dis_track1", int'(level_out), int'(tog_in));
    tog_in = ~tog_in;
    repeat (4) @(negedge clk);
    chk("dis_track2", int'(level_out), int'(tog_in));
    chk("dis_cnt_hold", int'(evt_cnt), 2);
    en = 1'b1;
    repeat (2) @(negedge clk);
    tog(3, 1'b0);
    repeat (8) @(negedge clk);
    chk("final_cnt", int'(evt_cnt), 3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_pulse: got none expected pulse at cycle %0d", e.c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
